// File: rtl/dmem_pkg.sv
// Shared address-field helpers and counter limits for the banked data memory.
// Field widths are derived from the bank geometry passed in by the instantiating block.
package dmem_pkg;

  localparam int          WORD_LSB = 2;
  localparam int          WORD_W   = 30;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  // Bits an index field occupies in the word address; zero when the field is absent.
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of a signal holding such an index; never zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [31:0] addr);
    return addr[31:WORD_LSB];
  endfunction

  function automatic logic out_of_range(input logic [WORD_W-1:0] word,
                                        input int num_banks, input int bank_words);
    return (word >> (field_w(num_banks) + field_w(bank_words))) != '0;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? CNT_MAX : sum[31:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = idx_w(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    gnt        = '0;
    w_found    = 1'b0;
    w_ptr_next = r_ptr;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        w_ptr_next = PW'((int'(w_idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/banked_dmem_arbiter.sv
// Multi-core data memory split into word-interleaved banks, each with its own
// round-robin arbiter; out-of-range accesses complete without touching a bank.
module banked_dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CORES-1:0]    req_valid,
  input  logic [NUM_CORES-1:0]    req_we,
  input  logic [NUM_CORES*32-1:0] req_addr,
  input  logic [NUM_CORES*32-1:0] req_wdata,
  output logic [NUM_CORES-1:0]    req_ready,
  output logic [NUM_CORES-1:0]    resp_valid,
  output logic [NUM_CORES*32-1:0] resp_rdata,
  output logic [NUM_CORES-1:0]    resp_err,
  output logic [31:0]             conflict_cnt
);

  localparam int BW  = idx_w(NUM_BANKS);
  localparam int BSH = field_w(NUM_BANKS);
  localparam int RW  = idx_w(BANK_WORDS);

  logic [WORD_W-1:0]    w_word       [NUM_CORES];
  logic [BW-1:0]        w_bank       [NUM_CORES];
  logic [RW-1:0]        w_row        [NUM_CORES];
  logic [NUM_CORES-1:0] w_oor;
  logic [NUM_CORES-1:0] w_bank_gnt   [NUM_BANKS];
  logic [31:0]          w_bank_rdata [NUM_BANKS];
  logic [NUM_CORES-1:0] w_granted;
  logic [31:0]          w_conflicts;

  logic [NUM_CORES-1:0] r_resp_valid;
  logic [NUM_CORES-1:0] r_resp_err;
  logic [NUM_CORES-1:0] r_is_read;
  logic [BW-1:0]        r_sel_bank   [NUM_CORES];
  logic [31:0]          r_hold       [NUM_CORES];
  logic [31:0]          r_conflict_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_decode
      assign w_word[gi] = word_of(req_addr[32*gi +: 32]);
      assign w_bank[gi] = BW'(w_word[gi] & WORD_W'(NUM_BANKS - 1));
      assign w_row[gi]  = RW'((w_word[gi] >> BSH) & WORD_W'(BANK_WORDS - 1));
      assign w_oor[gi]  = out_of_range(w_word[gi], NUM_BANKS, BANK_WORDS);
    end

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [NUM_CORES-1:0] w_req;
      logic [RW-1:0]        w_row_sel;
      logic                 w_we_sel;
      logic [31:0]          w_wdata_sel;
      logic [31:0]          r_mem [BANK_WORDS];
      logic [31:0]          r_rdata;

      always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
          w_req[i] = rst && req_valid[i] && !w_oor[i] && (w_bank[i] == BW'(gi));
        end
      end

      rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .gnt (w_bank_gnt[gi])
      );

      always_comb begin
        w_row_sel   = '0;
        w_we_sel    = 1'b0;
        w_wdata_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
          if (w_bank_gnt[gi][i]) begin
            w_row_sel   = w_row[i];
            w_we_sel    = req_we[i];
            w_wdata_sel = req_wdata[32*i +: 32];
          end
        end
      end

      // Read port samples the old row, so a read sees data as of its accepting edge.
      always_ff @(posedge clk) begin
        if (w_we_sel) begin
          r_mem[w_row_sel] <= w_wdata_sel;
        end
        r_rdata <= r_mem[w_row_sel];
      end

      assign w_bank_rdata[gi] = r_rdata;
    end
  endgenerate

  always_comb begin
    w_granted = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_granted = w_granted | w_bank_gnt[b];
    end
  end

  assign req_ready = req_valid & {NUM_CORES{rst}} & (w_granted | w_oor);

  always_comb begin
    w_conflicts = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (req_valid[i] && !w_oor[i] && !req_ready[i]) begin
        w_conflicts = w_conflicts + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resp_valid   <= '0;
      r_resp_err     <= '0;
      r_is_read      <= '0;
      r_conflict_cnt <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_hold[i]     <= '0;
        r_sel_bank[i] <= '0;
      end
    end else begin
      r_resp_valid   <= req_ready;
      r_resp_err     <= req_ready & w_oor;
      r_is_read      <= req_ready & ~req_we & ~w_oor;
      r_conflict_cnt <= sat_add(r_conflict_cnt, w_conflicts);
      for (int i = 0; i < NUM_CORES; i++) begin
        r_hold[i] <= resp_rdata[32*i +: 32];
        if (req_ready[i]) begin
          r_sel_bank[i] <= w_bank[i];
        end
      end
    end
  end

  // Masking with rst drops any response still in flight when reset arrives.
  assign resp_valid   = r_resp_valid & {NUM_CORES{rst}};
  assign resp_err     = r_resp_err & {NUM_CORES{rst}};
  assign conflict_cnt = r_conflict_cnt;

  always_comb begin
    resp_rdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (resp_valid[i]) begin
        resp_rdata[32*i +: 32] = r_is_read[i] ? w_bank_rdata[r_sel_bank[i]] : 32'd0;
      end else begin
        resp_rdata[32*i +: 32] = r_hold[i];
      end
    end
  end

endmodule

// File: tb/tb_banked_dmem_arbiter.sv
// Bench for banked_dmem_arbiter: vector table, directed corner sequences and
// randomized traffic checked each cycle against a word-level memory model.
module tb_banked_dmem_arbiter;

  localparam int NC  = 4;
  localparam int NB  = 4;
  localparam int BWD = 256;
  localparam int NW  = NB * BWD;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] req_valid, req_we, req_ready, resp_valid, resp_err;
  logic [NC*32-1:0] req_addr, req_wdata, resp_rdata;
  logic [31:0]   conflict_cnt;

  banked_dmem_arbiter #(.NUM_CORES(NC), .NUM_BANKS(NB), .BANK_WORDS(BWD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: flat word memory, per-bank pointers, pending responses.
  logic [31:0]   m_mem   [NW];
  bit            m_known [NW];
  int            m_ptr   [NB];
  logic [NC-1:0] m_valid, m_err;
  logic [31:0]   m_hold  [NC];
  bit            m_hknown[NC];
  longint        m_cnt;

  logic [NC-1:0] last_ready, last_rvalid, last_rerr, last_acc;
  logic [31:0]   last_rdata [NC];
  logic [31:0]   last_cnt;

  typedef struct packed {
    logic [NC-1:0]    valid;
    logic [NC-1:0]    we;
    logic [NC*32-1:0] addr;
    logic [NC-1:0]    exp_ready;
    logic [31:0]      exp_cnt;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] a_of(input int i);
    return req_addr[32*i +: 32];
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    return int'(a[31:2]) >= NW || a[31];
  endfunction

  function automatic logic [NC*32-1:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [31:0] a2, input logic [31:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Per bank, the winner is the eligible core at the smallest circular distance from the pointer.
  function automatic logic [NC-1:0] model_grant();
    logic [NC-1:0] g;
    logic [31:0]   a;
    int best, bestd, d;
    g = '0;
    if (!rst) return g;
    for (int i = 0; i < NC; i++) begin
      if (req_valid[i] && is_oor(a_of(i))) g[i] = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      best  = -1;
      bestd = NC;
      for (int i = 0; i < NC; i++) begin
        a = a_of(i);
        if (req_valid[i] && !is_oor(a) && (int'(a[31:2]) % NB) == b) begin
          d = (i - m_ptr[b] + NC) % NC;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
      if (best >= 0) g[best] = 1'b1;
    end
    return g;
  endfunction

  task automatic set_req(input int i, input bit v, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
  endtask

  // Compare DUT outputs at the falling edge, then advance the model across the next rising edge.
  task automatic tick();
    logic [NC-1:0] g, vis;
    logic [31:0]   a;
    int            w;
    longint        c;
    @(negedge clk);
    g = model_grant();
    last_acc    = g;
    last_ready  = req_ready;
    last_rvalid = resp_valid;
    last_rerr   = resp_err;
    last_cnt    = conflict_cnt;
    for (int i = 0; i < NC; i++) last_rdata[i] = resp_rdata[32*i +: 32];
    vis = rst ? m_valid : '0;
    chk("req_ready", req_ready, g);
    chk("resp_valid", resp_valid, vis);
    chk("conflict_cnt", conflict_cnt, m_cnt[31:0]);
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        if (m_hknown[i]) chk($sformatf("resp_rdata[%0d]", i), last_rdata[i], m_hold[i]);
        if (m_valid[i])  chk($sformatf("resp_err[%0d]", i), resp_err[i], m_err[i]);
      end
    end
    if (!rst) begin
      m_valid = '0;
      m_err   = '0;
      m_cnt   = 0;
      for (int b = 0; b < NB; b++) m_ptr[b] = 0;
      for (int i = 0; i < NC; i++) begin
        m_hold[i]   = '0;
        m_hknown[i] = 1'b1;
      end
    end else begin
      c = m_cnt;
      for (int i = 0; i < NC; i++) begin
        a = a_of(i);
        if (req_valid[i] && !g[i] && !is_oor(a)) c++;
      end
      m_cnt = (c > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : c;
      for (int i = 0; i < NC; i++) begin
        m_valid[i] = g[i];
        if (g[i]) begin
          a = a_of(i);
          m_err[i] = is_oor(a);
          if (is_oor(a) || req_we[i]) begin
            m_hold[i]   = '0;
            m_hknown[i] = 1'b1;
          end else begin
            w           = int'(a[31:2]);
            m_hold[i]   = m_mem[w];
            m_hknown[i] = m_known[w];
          end
        end
      end
      for (int i = 0; i < NC; i++) begin
        a = a_of(i);
        if (g[i] && !is_oor(a)) begin
          w = int'(a[31:2]);
          if (req_we[i]) begin
            m_mem[w]   = req_wdata[32*i +: 32];
            m_known[w] = 1'b1;
          end
          m_ptr[w % NB] = (i + 1) % NC;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_valid   = '0;
    m_err     = '0;
    m_cnt     = 0;
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    for (int i = 0; i < NC; i++) begin
      m_hold[i]   = '0;
      m_hknown[i] = 1'b1;
    end
    for (int w = 0; w < NW; w++) begin
      m_mem[w]   = '0;
      m_known[w] = 1'b0;
    end

    tbl[0] = '{valid: 4'b1111, we: 4'b1111, addr: pack4(32'h0, 32'h4, 32'h8, 32'hC),
               exp_ready: 4'b1111, exp_cnt: 32'd0};
    tbl[1] = '{valid: 4'b1111, we: 4'b0000, addr: pack4(32'h10, 32'h10, 32'h10, 32'h10),
               exp_ready: 4'b0001, exp_cnt: 32'd3};
    tbl[2] = '{valid: 4'b1110, we: 4'b1010, addr: pack4(32'h10, 32'h10, 32'h10, 32'h14),
               exp_ready: 4'b1010, exp_cnt: 32'd1};
    tbl[3] = '{valid: 4'b0101, we: 4'b0000, addr: pack4(32'h10000, 32'h0, 32'h10000, 32'h0),
               exp_ready: 4'b0101, exp_cnt: 32'd0};
    tbl[4] = '{valid: 4'b1111, we: 4'b0000, addr: pack4(32'h0, 32'h20000, 32'h4, 32'h40),
               exp_ready: 4'b0111, exp_cnt: 32'd1};
    tbl[5] = '{valid: 4'b0000, we: 4'b0000, addr: pack4(32'h0, 32'h0, 32'h0, 32'h0),
               exp_ready: 4'b0000, exp_cnt: 32'd0};
    tbl[6] = '{valid: 4'b1100, we: 4'b1100, addr: pack4(32'h0, 32'h0, 32'hFFC, 32'h1000),
               exp_ready: 4'b1100, exp_cnt: 32'd0};

    tick();
    tick();
    chk("reset resp_valid", {28'd0, last_rvalid}, 32'd0);
    chk("reset conflict_cnt", last_cnt, 32'd0);

    // Vector table: each row starts from reset so all pointers are zero.
    for (int r = 0; r < 7; r++) begin
      rst       = 1'b0;
      req_valid = '0;
      tick();
      rst       = 1'b1;
      req_valid = tbl[r].valid;
      req_we    = tbl[r].we;
      req_addr  = tbl[r].addr;
      for (int i = 0; i < NC; i++) req_wdata[32*i +: 32] = 32'hA0 + i + 16 * r;
      tick();
      chk($sformatf("tbl%0d ready", r), {28'd0, last_ready}, {28'd0, tbl[r].exp_ready});
      req_valid = '0;
      tick();
      chk($sformatf("tbl%0d resp_valid", r), {28'd0, last_rvalid}, {28'd0, tbl[r].exp_ready});
      chk($sformatf("tbl%0d conflict_cnt", r), last_cnt, tbl[r].exp_cnt);
    end

    // Fill every word so later reads have a known reference value.
    for (int k = 0; k < BWD; k++) begin
      for (int i = 0; i < NC; i++) set_req(i, 1'b1, 1'b1, 32'((4 * k + i) * 4), $urandom);
      tick();
    end
    req_valid = '0;
    tick();

    // All cores contend for bank 0 and hold until served.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < NC; i++) set_req(i, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < NC; c++) begin
      tick();
      chk($sformatf("rr grant %0d", c), {28'd0, last_ready}, 32'd1 << c);
      req_valid[c] = 1'b0;
    end
    tick();
    chk("contention conflict_cnt", last_cnt, 32'd6);
    chk("contention core3 rdata", last_rdata[3], m_mem[4]);

    // Write by core 1 then read of the same word by core 2.
    set_req(1, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    tick();
    chk("raw write ready", {31'd0, last_ready[1]}, 32'd1);
    req_valid = '0;
    set_req(2, 1'b1, 1'b0, 32'h20, 32'h0);
    tick();
    req_valid = '0;
    tick();
    chk("raw resp_valid", {31'd0, last_rvalid[2]}, 32'd1);
    chk("raw rdata", last_rdata[2], 32'hDEADBEEF);

    // Out-of-range read and write.
    set_req(3, 1'b1, 1'b0, 32'h10000, 32'h0);
    tick();
    chk("oor ready", {31'd0, last_ready[3]}, 32'd1);
    req_valid = '0;
    tick();
    chk("oor err", {31'd0, last_rerr[3]}, 32'd1);
    chk("oor rdata", last_rdata[3], 32'd0);
    set_req(3, 1'b1, 1'b1, 32'h10000, 32'h12345678);
    tick();
    req_valid = '0;
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    req_valid = '0;
    tick();
    chk("oor write discarded", last_rdata[0], m_mem[0]);

    // Reset right after a grant: response suppressed, state cleared, memory kept.
    set_req(0, 1'b1, 1'b1, 32'h30, 32'h55AA55AA);
    tick();
    req_valid = '0;
    rst       = 1'b0;
    tick();
    chk("reset drops resp", {28'd0, last_rvalid}, 32'd0);
    rst = 1'b1;
    tick();
    chk("post-reset conflict_cnt", last_cnt, 32'd0);
    set_req(0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h30, 32'h0);
    tick();
    chk("post-reset pointer", {28'd0, last_ready}, 32'd1);
    req_valid[0] = 1'b0;
    tick();
    chk("post-reset resp_valid", {31'd0, last_rvalid[0]}, 32'd1);
    chk("data survives reset", last_rdata[0], 32'h55AA55AA);
    req_valid = '0;
    tick();

    // Randomized traffic with hold-until-granted behaviour and occasional resets.
    last_acc = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (!req_valid[i] || last_acc[i]) begin
          if ($urandom_range(0, 15) == 0)
            set_req(i, $urandom_range(0, 3) != 0, 1'($urandom), $urandom | 32'h1000, $urandom);
          else
            set_req(i, $urandom_range(0, 3) != 0, 1'($urandom), 32'($urandom_range(0, 127)), $urandom);
        end
      end
      rst = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
